// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file written by the write-back stage, plus a per-register count of
//   in-flight (issued but not yet committed) destination writes. Decode reads two
//   operands with same-cycle write-to-read bypass and gets per-operand busy flags
//   for RAW stalls. Decode allocates a pending write at issue; write-back retires it.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   read1RegSel/read2RegSel         operand register selects
//   read1En/read2En                 operand is used by the decoding instruction
//   read1Data/read2Data             operand data, bypassed from write-back
//   read1Busy/read2Busy             operand has an unretired producer
//   issueEn/issueRegSel             allocate a pending write on issueRegSel
//   issueFull                       pending count of issueRegSel is saturated
//   writeEn/writeRegSel/writeData   write-back commit
//   err                             sticky protocol error
module regfile_scoreboard #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PEND_W   = 2,
  localparam int unsigned SEL_W   = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] read1RegSel,
  input  logic [SEL_W-1:0] read2RegSel,
  input  logic             read1En,
  input  logic             read2En,
  output logic [WIDTH-1:0] read1Data,
  output logic [WIDTH-1:0] read2Data,
  output logic             read1Busy,
  output logic             read2Busy,
  input  logic             issueEn,
  input  logic [SEL_W-1:0] issueRegSel,
  output logic             issueFull,
  input  logic             writeEn,
  input  logic [SEL_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0] writeData,
  output logic             err
);

  localparam logic [PEND_W-1:0] PendMax = '1;

  logic [WIDTH-1:0]  regs_q [NUM_REGS];
  logic [PEND_W-1:0] pend_q [NUM_REGS];
  logic [PEND_W-1:0] pend_d [NUM_REGS];
  logic              err_q, err_d;

  logic retire1, retire2, issueRetire;
  logic issueOk, issueDrop, writeNoAlloc, ctrlUnknown;

  // Read path: bypass the committing write-back value.
  always_comb begin
    read1Data = regs_q[read1RegSel];
    read2Data = regs_q[read2RegSel];
    if (writeEn && (writeRegSel == read1RegSel)) read1Data = writeData;
    if (writeEn && (writeRegSel == read2RegSel)) read2Data = writeData;
  end

  // A retiring last producer does not stall: its data is on the bypass.
  always_comb begin
    retire1   = writeEn && (writeRegSel == read1RegSel) && (pend_q[read1RegSel] != '0);
    retire2   = writeEn && (writeRegSel == read2RegSel) && (pend_q[read2RegSel] != '0);
    read1Busy = read1En && ((pend_q[read1RegSel] - PEND_W'(retire1)) != '0);
    read2Busy = read2En && ((pend_q[read2RegSel] - PEND_W'(retire2)) != '0);
  end

  // A same-cycle retire frees a slot, so a saturated register can still accept an issue.
  always_comb begin
    issueRetire  = writeEn && (writeRegSel == issueRegSel);
    issueFull    = (pend_q[issueRegSel] == PendMax) && !issueRetire;
    issueOk      = issueEn && !issueFull;
    issueDrop    = issueEn && issueFull;
    writeNoAlloc = writeEn && (pend_q[writeRegSel] == '0);
    ctrlUnknown  = $isunknown({writeEn, issueEn});
    err_d        = err_q || issueDrop || writeNoAlloc || ctrlUnknown;
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      logic inc, dec;
      inc = issueOk && (issueRegSel == SEL_W'(r));
      dec = writeEn && (writeRegSel == SEL_W'(r)) && (pend_q[r] != '0);
      pend_d[r] = pend_q[r];
      if (inc && !dec)      pend_d[r] = pend_q[r] + 1'b1;
      else if (dec && !inc) pend_d[r] = pend_q[r] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (writeEn) regs_q[writeRegSel] <= writeData;
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule
